// File: rtl/ariane_pkg.sv
// Shared core constants for the PMP configuration byte layout.
package ariane_pkg;

    localparam int unsigned PMP_CFG_W    = 8;
    localparam int unsigned PMP_LOCK_BIT = 7;

endpackage

// File: rtl/config_pkg.sv
// Elaborated core configuration: only the fields the PMP reset path consumes.
package config_pkg;

    localparam int unsigned MaxPMPEntries = 16;

    typedef struct packed {
        int unsigned                          NrPMPEntries;
        logic [MaxPMPEntries-1:0][63:0]       PMPCfgRstVal;
        logic [MaxPMPEntries-1:0][63:0]       PMPAddrRstVal;
        logic [MaxPMPEntries-1:0]             PMPEntryReadOnly;
        int unsigned                          PLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        NrPMPEntries:     32'd0,
        PMPCfgRstVal:     '0,
        PMPAddrRstVal:    '0,
        PMPEntryReadOnly: '0,
        PLEN:             32'd34
    };

endpackage

// File: rtl/pmp_reset_loader.sv
// Post-reset PMP sequencer: streams per-entry reset values into the CSR PMP write port.
// Optional lock forcing for read-only entries is enabled by defining CVA6_PMP_RESET_LOCK_EN.
module pmp_reset_loader
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned IdxW = (CVA6Cfg.NrPMPEntries > 1) ? $clog2(CVA6Cfg.NrPMPEntries) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         pmp_we_o,
    input  logic                         pmp_ready_i,
    output logic [IdxW-1:0]              pmp_idx_o,
    output logic [PMP_CFG_W-1:0]         pmp_cfg_o,
    output logic [CVA6Cfg.PLEN-3:0]      pmp_addr_o,
    output logic [((CVA6Cfg.NrPMPEntries > 0) ? CVA6Cfg.NrPMPEntries : 1)-1:0] lock_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         hold_fetch_o
);

    localparam int unsigned NrEntries = CVA6Cfg.NrPMPEntries;
    localparam int unsigned LockW     = (NrEntries > 0) ? NrEntries : 1;
    localparam int unsigned SelW      = $clog2(config_pkg::MaxPMPEntries);
    localparam logic [IdxW-1:0] LastIdx = IdxW'((NrEntries > 0) ? NrEntries - 1 : 0);
    localparam logic NoEntries = (NrEntries == 0);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    logic                accept;
    logic [SelW-1:0]     sel;
    logic [PMP_CFG_W-1:0] cfg_byte;

    assign accept = (state_q == LOAD) & pmp_ready_i;
    assign sel    = SelW'(cnt_q);

    // Next-state and entry counter; terminal compare happens before the increment.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d   = '0;
                state_d = NoEntries ? DONE : LOAD;
            end
            LOAD: begin
                if (pmp_ready_i) begin
                    if (cnt_q == LastIdx) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d = NoEntries ? DONE : LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CVA6_PMP_RESET_LOCK_EN
    logic [LockW-1:0] lock_q, lock_d;

    // Read-only entries get the L bit forced in the byte sent to the CSR file.
    always_comb begin
        cfg_byte = CVA6Cfg.PMPCfgRstVal[sel][PMP_CFG_W-1:0];
        if (CVA6Cfg.PMPEntryReadOnly[sel]) begin
            cfg_byte[PMP_LOCK_BIT] = 1'b1;
        end else begin
            cfg_byte[PMP_LOCK_BIT] = CVA6Cfg.PMPCfgRstVal[sel][PMP_LOCK_BIT];
        end
    end

    // Lock flags are sticky across restarts; only the hard reset clears them.
    always_comb begin
        lock_d = lock_q;
        for (int i = 0; i < LockW; i++) begin
            lock_d[i] = lock_q[i] | (accept & (cnt_q == IdxW'(i)) & CVA6Cfg.PMPEntryReadOnly[i]);
        end
    end

    // Lock flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock_o = lock_q;
`else
    assign cfg_byte = CVA6Cfg.PMPCfgRstVal[sel][PMP_CFG_W-1:0];
    assign lock_o   = '0;
`endif

    assign pmp_we_o     = (state_q == LOAD);
    assign pmp_idx_o    = cnt_q;
    assign pmp_cfg_o    = (state_q == LOAD) ? cfg_byte : '0;
    assign pmp_addr_o   = (state_q == LOAD) ? CVA6Cfg.PMPAddrRstVal[sel][CVA6Cfg.PLEN-3:0] : '0;
    assign busy_o       = (state_q != DONE);
    assign done_o       = (state_q == DONE);
    assign hold_fetch_o = (state_q != DONE);

endmodule

// File: tb/tb_pmp_reset_loader.sv
// Directed bench: 4-entry loader (a), 4-entry loader with a read-only entry (c), 0-entry loader (z).
module tb_pmp_reset_loader;

    function automatic config_pkg::cva6_cfg_t mk_cfg(input int unsigned n, input logic [63:0] c2,
                                                     input logic [63:0] c3, input logic [15:0] ro);
        config_pkg::cva6_cfg_t c;
        c = config_pkg::cva6_cfg_empty;
        c.NrPMPEntries     = n;
        c.PLEN             = 32'd34;
        c.PMPCfgRstVal[0]  = 64'h1F;
        c.PMPCfgRstVal[1]  = 64'h0F;
        c.PMPCfgRstVal[2]  = c2;
        c.PMPCfgRstVal[3]  = c3;
        c.PMPAddrRstVal[0] = 64'h0000_0003_8000_0010;
        c.PMPAddrRstVal[1] = 64'h0000_0000_2000_0000;
        c.PMPAddrRstVal[2] = 64'hFFFF_FFFF_1234_5678;
        c.PMPAddrRstVal[3] = 64'h0000_0001_0000_00FF;
        c.PMPEntryReadOnly = ro;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t CFG_A = mk_cfg(4, 64'h00, 64'h18, 16'h0000);
    localparam config_pkg::cva6_cfg_t CFG_C = mk_cfg(4, 64'h18, 64'h00, 16'h0004);
    localparam config_pkg::cva6_cfg_t CFG_Z = mk_cfg(0, 64'h00, 64'h00, 16'h0000);

`ifdef CVA6_PMP_RESET_LOCK_EN
    localparam logic [7:0] C_CFG2  = 8'h98;
    localparam logic [3:0] C_LOCK  = 4'b0100;
`else
    localparam logic [7:0] C_CFG2  = 8'h18;
    localparam logic [3:0] C_LOCK  = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, ready_a = 1'b1;
    logic        start_c = 1'b0, ready_c = 1'b1;
    logic        start_z = 1'b0, ready_z = 1'b1;

    logic        we_a, busy_a, done_a, hold_a;
    logic [1:0]  idx_a;
    logic [7:0]  cfg_a;
    logic [31:0] addr_a;
    logic [3:0]  lock_a;

    logic        we_c, busy_c, done_c, hold_c;
    logic [1:0]  idx_c;
    logic [7:0]  cfg_c;
    logic [31:0] addr_c;
    logic [3:0]  lock_c;

    logic        we_z, busy_z, done_z, hold_z;
    logic [0:0]  idx_z;
    logic [7:0]  cfg_z;
    logic [31:0] addr_z;
    logic [0:0]  lock_z;

    int checks = 0;
    int errors = 0;
    int acc_a  = 0;
    logic we_z_seen = 1'b0;

    logic [7:0]  exp_cfg  [4] = '{8'h1F, 8'h0F, 8'h00, 8'h18};
    logic [31:0] exp_addr [4] = '{32'h8000_0010, 32'h2000_0000, 32'h1234_5678, 32'h0000_00FF};

    pmp_reset_loader #(.CVA6Cfg(CFG_A)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .pmp_we_o(we_a), .pmp_ready_i(ready_a),
        .pmp_idx_o(idx_a), .pmp_cfg_o(cfg_a), .pmp_addr_o(addr_a), .lock_o(lock_a),
        .busy_o(busy_a), .done_o(done_a), .hold_fetch_o(hold_a));

    pmp_reset_loader #(.CVA6Cfg(CFG_C)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .pmp_we_o(we_c), .pmp_ready_i(ready_c),
        .pmp_idx_o(idx_c), .pmp_cfg_o(cfg_c), .pmp_addr_o(addr_c), .lock_o(lock_c),
        .busy_o(busy_c), .done_o(done_c), .hold_fetch_o(hold_c));

    pmp_reset_loader #(.CVA6Cfg(CFG_Z)) u_z (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_z), .pmp_we_o(we_z), .pmp_ready_i(ready_z),
        .pmp_idx_o(idx_z), .pmp_cfg_o(cfg_z), .pmp_addr_o(addr_z), .lock_o(lock_z),
        .busy_o(busy_z), .done_o(done_z), .hold_fetch_o(hold_z));

    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so mid-cycle sampling sees the upcoming handshake.
    always @(negedge clk) begin
        if (rst_n && we_a && ready_a) acc_a++;
        if (we_z) we_z_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_a_load(input string tag, input int i);
        chk({tag, "_we"},   {63'd0, we_a}, 64'd1);
        chk({tag, "_idx"},  {62'd0, idx_a}, 64'(i));
        chk({tag, "_cfg"},  {56'd0, cfg_a}, {56'd0, exp_cfg[i]});
        chk({tag, "_addr"}, {32'd0, addr_a}, {32'd0, exp_addr[i]});
        chk({tag, "_busy"}, {63'd0, busy_a}, 64'd1);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_we"},   {63'd0, we_a}, 64'd0);
        chk({tag, "_idx"},  {62'd0, idx_a}, 64'd0);
        chk({tag, "_cfg"},  {56'd0, cfg_a}, 64'd0);
        chk({tag, "_addr"}, {32'd0, addr_a}, 64'd0);
        chk({tag, "_lock"}, {60'd0, lock_a}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_a}, 64'd1);
        chk({tag, "_done"}, {63'd0, done_a}, 64'd0);
        chk({tag, "_hold"}, {63'd0, hold_a}, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_a_reset("rst");
        chk("rst_lock_c", {60'd0, lock_c}, 64'd0);
        chk("rst_done_z", {63'd0, done_z}, 64'd0);

        // Release between edges: cycle 1 is INIT.
        rst_n = 1'b1;
        #1;
        chk("c1_we",   {63'd0, we_a}, 64'd0);
        chk("c1_busy", {63'd0, busy_a}, 64'd1);
        chk("c1_done_z", {63'd0, done_z}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            next_cyc();
            chk_a_load($sformatf("run1_i%0d", i), i);
            if (i == 0) begin
                chk("z_done_c2", {63'd0, done_z}, 64'd1);
                chk("z_busy_c2", {63'd0, busy_z}, 64'd0);
            end
            if (i == 2) begin
                chk("c_idx2",    {62'd0, idx_c}, 64'd2);
                chk("c_cfg2",    {56'd0, cfg_c}, {56'd0, C_CFG2});
            end
        end
        next_cyc();
        chk("c6_done", {63'd0, done_a}, 64'd1);
        chk("c6_we",   {63'd0, we_a}, 64'd0);
        chk("c6_busy", {63'd0, busy_a}, 64'd0);
        chk("c6_hold", {63'd0, hold_a}, 64'd0);
        chk("c6_acc",  64'(acc_a), 64'd4);
        chk("c6_lock_c", {60'd0, lock_c}, {60'd0, C_LOCK});
        chk("c6_lock_a", {60'd0, lock_a}, 64'd0);

        // Restart both; stall a on idx 1 and pulse start mid-LOAD.
        acc_a   = 0;
        start_a = 1'b1;
        start_c = 1'b1;
        next_cyc();
        start_a = 1'b0;
        start_c = 1'b0;
        chk_a_load("rs_i0", 0);
        chk("rs_lock_c", {60'd0, lock_c}, {60'd0, C_LOCK});
        next_cyc();
        chk_a_load("rs_i1", 1);
        ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_a = (k == 1);
            next_cyc();
            chk_a_load($sformatf("stall%0d", k), 1);
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        next_cyc();
        chk_a_load("rs_i2", 2);
        next_cyc();
        chk_a_load("rs_i3", 3);
        next_cyc();
        chk("rs_done", {63'd0, done_a}, 64'd1);
        chk("rs_acc",  64'(acc_a), 64'd4);
        chk("rs_lock_c_done", {60'd0, lock_c}, {60'd0, C_LOCK});

        // Hard reset in the middle of idx 2.
        start_a = 1'b1;
        next_cyc();
        start_a = 1'b0;
        next_cyc();
        next_cyc();
        chk("mid_idx", {62'd0, idx_a}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk_a_reset("mid_rst");
        chk("mid_rst_lock_c", {60'd0, lock_c}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_we", {63'd0, we_a}, 64'd0);
        next_cyc();
        chk_a_load("rel_i0", 0);

        chk("z_never_we", {63'd0, we_z_seen}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
